// File: rtl/mem_ctrl_lat_pkg.sv
// mem_pkg: shared definitions for the latency-configurable dual-port memory.
//   - access-type codes carried in rwtyp[1:0] and the zero-extend bit index
//   - per-port handshake FSM state encoding
//   - helpers for fault detection, byte enables, store lane replication and
//     load lane selection / extension
package mem_pkg;

    localparam logic [1:0] RW_BYTE = 2'b00;
    localparam logic [1:0] RW_HALF = 2'b01;
    localparam logic [1:0] RW_WORD = 2'b10;
    localparam logic [1:0] RW_ILL  = 2'b11;
    localparam int unsigned RW_UNSIGNED = 2;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BUSY,
        ST_RESP
    } state_e;

    // Alignment / type fault, independent of the address range check.
    function automatic logic access_fault(input logic [1:0] typ, input logic [1:0] lo);
        logic f;
        case (typ)
            RW_BYTE: f = 1'b0;
            RW_HALF: f = lo[0];
            RW_WORD: f = (lo != 2'b00);
            default: f = 1'b1;
        endcase
        return f;
    endfunction

    function automatic logic [3:0] byte_en(input logic [1:0] typ, input logic [1:0] lo);
        logic [3:0] be;
        case (typ)
            RW_BYTE: be = 4'b0001 << lo;
            RW_HALF: be = lo[1] ? 4'b1100 : 4'b0011;
            RW_WORD: be = 4'b1111;
            default: be = 4'b0000;
        endcase
        return be;
    endfunction

    // Replicate right-aligned store data across every lane; byte enables pick the lane.
    function automatic logic [31:0] store_lanes(input logic [1:0] typ, input logic [31:0] wdata);
        logic [31:0] l;
        case (typ)
            RW_BYTE: l = {4{wdata[7:0]}};
            RW_HALF: l = {2{wdata[15:0]}};
            default: l = wdata;
        endcase
        return l;
    endfunction

    // Shift the addressed lane down to bit 0, then extend to 32 bits.
    function automatic logic [31:0] load_ext(input logic [31:0] word, input logic [2:0] typ,
                                             input logic [1:0] lo);
        logic [31:0] sh;
        logic [31:0] r;
        sh = word >> {lo, 3'b000};
        case (typ[1:0])
            RW_BYTE: r = typ[RW_UNSIGNED] ? {24'b0, sh[7:0]} : {{24{sh[7]}}, sh[7:0]};
            RW_HALF: r = typ[RW_UNSIGNED] ? {16'b0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
            default: r = word;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/mem_ctrl_lat_if.sv
// mem_ctrl_lat_if: instruction and data port handshake bundle.
//   master: core side (fetch unit + LSU) drives requests and response-ready.
//   slave : memory side drives request-ready and responses.
interface mem_ctrl_lat_if;
    import mem_pkg::*;

    logic        d_req_valid;
    logic        d_req_ready;
    logic        d_req_wen;
    logic [2:0]  d_req_rwtyp;
    logic [31:0] d_req_addr;
    logic [31:0] d_req_wdata;
    logic        d_resp_valid;
    logic        d_resp_ready;
    logic [31:0] d_resp_rdata;
    logic        d_resp_err;

    logic        i_req_valid;
    logic        i_req_ready;
    logic [31:0] i_req_addr;
    logic        i_resp_valid;
    logic        i_resp_ready;
    logic [31:0] i_resp_inst;
    logic        i_resp_err;

    modport master (
        output d_req_valid, d_req_wen, d_req_rwtyp, d_req_addr, d_req_wdata, d_resp_ready,
        output i_req_valid, i_req_addr, i_resp_ready,
        input  d_req_ready, d_resp_valid, d_resp_rdata, d_resp_err,
        input  i_req_ready, i_resp_valid, i_resp_inst, i_resp_err
    );

    modport slave (
        input  d_req_valid, d_req_wen, d_req_rwtyp, d_req_addr, d_req_wdata, d_resp_ready,
        input  i_req_valid, i_req_addr, i_resp_ready,
        output d_req_ready, d_resp_valid, d_resp_rdata, d_resp_err,
        output i_req_ready, i_resp_valid, i_resp_inst, i_resp_err
    );

endinterface

// File: rtl/mem_ctrl_lat_port.sv
// mem_lat_port: one-outstanding-transaction handshake FSM with fixed latency.
//   req_valid/req_ready : request handshake (accept = valid & ready)
//   fire                : high in the cycle whose closing edge enters RESP;
//                         the parent performs its array access on that edge
//   resp_data_in/err_in : response payload captured on the fire edge
//   resp_valid/data/err : registered response, held until resp_ready
module mem_lat_port
    import mem_pkg::*;
#(
    parameter int unsigned LAT = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    output logic        accept,
    output logic        fire,
    input  logic [31:0] resp_data_in,
    input  logic        resp_err_in,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_data,
    output logic        resp_err
);

    localparam int unsigned CW = (LAT > 1) ? $clog2(LAT) : 1;
    localparam logic [CW-1:0] LOAD = CW'(LAT - 1);

    state_e        state;
    logic [CW-1:0] cnt;

    assign accept = req_valid && req_ready;
    // LAT=1 commits on the accept edge itself; otherwise on the last BUSY cycle.
    assign fire = (LAT == 1) ? accept : ((state == ST_BUSY) && (cnt == CW'(1)));

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_data  <= '0;
            resp_err   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        req_ready <= 1'b0;
                        if (fire) begin
                            state      <= ST_RESP;
                            resp_valid <= 1'b1;
                            resp_data  <= resp_data_in;
                            resp_err   <= resp_err_in;
                        end else begin
                            state <= ST_BUSY;
                            cnt   <= LOAD;
                        end
                    end
                end
                ST_BUSY: begin
                    if (fire) begin
                        state      <= ST_RESP;
                        resp_valid <= 1'b1;
                        resp_data  <= resp_data_in;
                        resp_err   <= resp_err_in;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                ST_RESP: begin
                    if (resp_ready) begin
                        state      <= ST_IDLE;
                        resp_valid <= 1'b0;
                        req_ready  <= 1'b1;
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    req_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: rtl/mem_ctrl_lat.sv
// mem_ctrl_lat: dual-port (I/D) word memory with valid/ready handshakes,
// per-port latency, base/size decode and access-fault reporting.
//   clk, rst : single clock, synchronous active-high reset
//   bus      : mem_ctrl_lat_if.slave carrying the d_* data port and i_* fetch port
// The array is read and written on the edge that moves a port into RESP.
// A faulting access returns err=1 with zero data and never writes.
module mem_ctrl_lat
    import mem_pkg::*;
#(
    parameter logic [31:0] ADDR_BASE   = 32'h8000_0000,
    parameter int unsigned DEPTH_WORDS = 1 << 17,
    parameter int unsigned I_LAT       = 1,
    parameter int unsigned D_LAT       = 2,
    parameter string       INIT_FILE   = ""
) (
    input logic clk,
    input logic rst,
    mem_ctrl_lat_if.slave bus
);

    localparam int unsigned AW = $clog2(DEPTH_WORDS);
    localparam logic [32:0] SIZE_BYTES = 33'(DEPTH_WORDS) << 2;

    logic [31:0] mem [DEPTH_WORDS];

    // ---------------- data port ----------------
    logic        d_acc, d_fire;
    logic        d_wen_q;
    logic [2:0]  d_typ_q;
    logic [31:0] d_addr_q, d_wdata_q;
    logic        d_wen;
    logic [2:0]  d_typ;
    logic [31:0] d_addr, d_wdata, d_off, d_resp_in;
    logic [AW-1:0] d_idx;
    logic        d_err;
    logic [3:0]  d_be;
    logic [31:0] d_lanes;

    // With LAT=1 the commit edge is the accept edge, so the live request is
    // used in that cycle instead of the (not yet loaded) latched copy.
    assign d_wen   = d_acc ? bus.d_req_wen   : d_wen_q;
    assign d_typ   = d_acc ? bus.d_req_rwtyp : d_typ_q;
    assign d_addr  = d_acc ? bus.d_req_addr  : d_addr_q;
    assign d_wdata = d_acc ? bus.d_req_wdata : d_wdata_q;

    assign d_off     = d_addr - ADDR_BASE;
    assign d_idx     = d_off[AW+1:2];
    assign d_err     = ({1'b0, d_off} >= SIZE_BYTES) || access_fault(d_typ[1:0], d_addr[1:0]);
    assign d_be      = byte_en(d_typ[1:0], d_addr[1:0]);
    assign d_lanes   = store_lanes(d_typ[1:0], d_wdata);
    assign d_resp_in = (d_err || d_wen) ? '0 : load_ext(mem[d_idx], d_typ, d_addr[1:0]);

    always_ff @(posedge clk) begin
        if (rst) begin
            d_wen_q   <= 1'b0;
            d_typ_q   <= '0;
            d_addr_q  <= '0;
            d_wdata_q <= '0;
        end else if (d_acc) begin
            d_wen_q   <= bus.d_req_wen;
            d_typ_q   <= bus.d_req_rwtyp;
            d_addr_q  <= bus.d_req_addr;
            d_wdata_q <= bus.d_req_wdata;
        end
    end

    // Reset outranks a commit on the same edge.
    always_ff @(posedge clk) begin
        if (!rst && d_fire && d_wen && !d_err) begin
            for (int unsigned b = 0; b < 4; b++) begin
                if (d_be[b]) mem[d_idx][8*b +: 8] <= d_lanes[8*b +: 8];
            end
        end
    end

    mem_lat_port #(.LAT(D_LAT)) u_dport (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (bus.d_req_valid),
        .req_ready    (bus.d_req_ready),
        .accept       (d_acc),
        .fire         (d_fire),
        .resp_data_in (d_resp_in),
        .resp_err_in  (d_err),
        .resp_valid   (bus.d_resp_valid),
        .resp_ready   (bus.d_resp_ready),
        .resp_data    (bus.d_resp_rdata),
        .resp_err     (bus.d_resp_err)
    );

    // ---------------- fetch port ----------------
    logic        i_acc, i_fire;
    logic [31:0] i_addr_q, i_addr, i_off, i_resp_in;
    logic [AW-1:0] i_idx;
    logic        i_err;

    assign i_addr    = i_acc ? bus.i_req_addr : i_addr_q;
    assign i_off     = i_addr - ADDR_BASE;
    assign i_idx     = i_off[AW+1:2];
    assign i_err     = ({1'b0, i_off} >= SIZE_BYTES) || (i_addr[1:0] != 2'b00);
    assign i_resp_in = i_err ? '0 : mem[i_idx];

    always_ff @(posedge clk) begin
        if (rst)        i_addr_q <= '0;
        else if (i_acc) i_addr_q <= bus.i_req_addr;
    end

    mem_lat_port #(.LAT(I_LAT)) u_iport (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (bus.i_req_valid),
        .req_ready    (bus.i_req_ready),
        .accept       (i_acc),
        .fire         (i_fire),
        .resp_data_in (i_resp_in),
        .resp_err_in  (i_err),
        .resp_valid   (bus.i_resp_valid),
        .resp_ready   (bus.i_resp_ready),
        .resp_data    (bus.i_resp_inst),
        .resp_err     (bus.i_resp_err)
    );

endmodule
